// File: rtl/lea_dec_round_engine.sv
// lea_dec_round_engine: iterative LEA decryption, one inverse round per clock with keys requested by RoundIdx.
// Define LEA_DEC_ABORT_EN to add an Abort input that cancels a block in KEY or DONE.
module lea_rk_xor (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = a ^ b;
endmodule

module lea_dec_round_engine #(
  parameter int ROUNDS = 24,
  parameter int IDXW   = 5
) (
  input  logic            Clk,
  input  logic            Rst_n,
`ifdef LEA_DEC_ABORT_EN
  input  logic            Abort,
`endif
  input  logic            InValid,
  output logic            InReady,
  input  logic [127:0]    CipherText,
  input  logic            RkValid,
  output logic            RkReady,
  output logic [IDXW-1:0] RoundIdx,
  input  logic [191:0]    RoundKey,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [127:0]    PlainText,
  output logic            Busy
);
  typedef enum logic [1:0] {IDLE, KEY, DONE} state_t;
  state_t fsm;
  logic [127:0] st;
  logic [31:0] y0, y1, y2, y3, x0, x1, x2, x3, k0, k2, k4, d1, d2, d3;
  logic abort;
`ifdef LEA_DEC_ABORT_EN
  assign abort = Abort;
`else
  assign abort = 1'b0;
`endif
  assign {y3, y2, y1, y0} = st;
  assign x0 = y3;
  assign d1 = {y0[8:0], y0[31:9]} - k0;
  assign d2 = {y1[26:0], y1[31:27]} - k2;
  assign d3 = {y2[28:0], y2[31:29]} - k4;
  lea_rk_xor u_x0 (.a(x0), .b(RoundKey[31:0]),    .y(k0));
  lea_rk_xor u_x1 (.a(d1), .b(RoundKey[63:32]),   .y(x1));
  lea_rk_xor u_x2 (.a(x1), .b(RoundKey[95:64]),   .y(k2));
  lea_rk_xor u_x3 (.a(d2), .b(RoundKey[127:96]),  .y(x2));
  lea_rk_xor u_x4 (.a(x2), .b(RoundKey[159:128]), .y(k4));
  lea_rk_xor u_x5 (.a(d3), .b(RoundKey[191:160]), .y(x3));
  assign PlainText = st;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      fsm      <= IDLE;
      st       <= '0;
      RoundIdx <= '0;
      InReady  <= 1'b1;
      RkReady  <= 1'b0;
      OutValid <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (InValid) begin
          fsm      <= KEY;
          st       <= CipherText;
          RoundIdx <= IDXW'(ROUNDS - 1);
          InReady  <= 1'b0;
          RkReady  <= 1'b1;
          Busy     <= 1'b1;
        end
        KEY: if (abort) begin
          fsm      <= IDLE;
          RoundIdx <= '0;
          InReady  <= 1'b1;
          RkReady  <= 1'b0;
          Busy     <= 1'b0;
        end else if (RkValid) begin
          st <= {x3, x2, x1, x0};
          if (RoundIdx == '0) begin
            fsm      <= DONE;
            RkReady  <= 1'b0;
            OutValid <= 1'b1;
          end else
            RoundIdx <= RoundIdx - 1'b1;
        end
        DONE: if (abort || OutReady) begin
          fsm      <= IDLE;
          RoundIdx <= '0;
          InReady  <= 1'b1;
          OutValid <= 1'b0;
          Busy     <= 1'b0;
        end
        default: fsm <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_lea_dec_round_engine.sv
// tb_lea_dec_round_engine: directed vectors on a 1-round instance plus LEA-128 roundtrips on the 24-round instance.
module tb_lea_dec_round_engine;
  logic Clk = 0, Rst_n = 0;
  always #5 Clk = ~Clk;
  int total = 0, bad = 0;

  logic in_valid = 0, in_ready, rk_valid = 0, rk_ready, out_valid, out_ready = 0, busy, abort = 0;
  logic [4:0] round_idx;
  logic [127:0] ct = '0, pt;
  logic [191:0] round_key;
  logic [191:0] rk_tab [24];
  assign round_key = (round_idx < 5'd24) ? rk_tab[round_idx] : '0;

  logic in_valid1 = 0, in_ready1, rk_valid1 = 0, rk_ready1, out_valid1, out_ready1 = 0, busy1, abort1 = 0;
  logic [0:0] round_idx1;
  logic [127:0] ct1 = '0, pt1;
  logic [191:0] rk1 = '0;

  lea_dec_round_engine #(.ROUNDS(24), .IDXW(5)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
`ifdef LEA_DEC_ABORT_EN
    .Abort(abort),
`endif
    .InValid(in_valid), .InReady(in_ready), .CipherText(ct),
    .RkValid(rk_valid), .RkReady(rk_ready), .RoundIdx(round_idx), .RoundKey(round_key),
    .OutValid(out_valid), .OutReady(out_ready), .PlainText(pt), .Busy(busy));

  lea_dec_round_engine #(.ROUNDS(1), .IDXW(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n),
`ifdef LEA_DEC_ABORT_EN
    .Abort(abort1),
`endif
    .InValid(in_valid1), .InReady(in_ready1), .CipherText(ct1),
    .RkValid(rk_valid1), .RkReady(rk_ready1), .RoundIdx(round_idx1), .RoundKey(rk1),
    .OutValid(out_valid1), .OutReady(out_ready1), .PlainText(pt1), .Busy(busy1));

  typedef struct {
    logic [127:0] ct;
    logic [191:0] rk;
    logic [127:0] pt;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    int m = n % 32;
    return (m == 0) ? x : ((x << m) | (x >> (32 - m)));
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return rol(x, 32 - (n % 32));
  endfunction

  task automatic key_sched(input logic [127:0] key);
    logic [31:0] d [4];
    logic [31:0] t0, t1, t2, t3;
    d[0] = 32'hc3efe9db; d[1] = 32'h44626b02; d[2] = 32'h79e27c8a; d[3] = 32'h78df30ec;
    {t3, t2, t1, t0} = key;
    for (int i = 0; i < 24; i++) begin
      t0 = rol(t0 + rol(d[i % 4], i), 1);
      t1 = rol(t1 + rol(d[i % 4], i + 1), 3);
      t2 = rol(t2 + rol(d[i % 4], i + 2), 6);
      t3 = rol(t3 + rol(d[i % 4], i + 3), 11);
      rk_tab[i] = {t1, t3, t1, t2, t1, t0};
    end
  endtask

  function automatic logic [127:0] enc(input logic [127:0] p);
    logic [31:0] x0, x1, x2, x3, n0, n1, n2;
    logic [191:0] k;
    {x3, x2, x1, x0} = p;
    for (int i = 0; i < 24; i++) begin
      k = rk_tab[i];
      n0 = rol((x0 ^ k[31:0]) + (x1 ^ k[63:32]), 9);
      n1 = ror((x1 ^ k[95:64]) + (x2 ^ k[127:96]), 5);
      n2 = ror((x2 ^ k[159:128]) + (x3 ^ k[191:160]), 3);
      x3 = x0; x0 = n0; x1 = n1; x2 = n2;
    end
    return {x3, x2, x1, x0};
  endfunction

  // Runs one block through the 24-round DUT; leaves it in DONE.
  task automatic run_block(input logic [127:0] c, input bit rnd, output logic [127:0] got, output int lat, output bit idx_ok);
    logic [4:0] prev;
    bit fired;
    in_valid = 1; ct = c; rk_valid = 0;
    tick;
    in_valid = 0;
    lat = 1;
    idx_ok = (round_idx == 5'd23) && rk_ready;
    while (!out_valid && lat < 300) begin
      rk_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      fired = rk_valid;
      prev = round_idx;
      tick;
      lat++;
      if (!out_valid && round_idx !== (fired ? prev - 5'd1 : prev)) idx_ok = 0;
      if (out_valid && prev !== 5'd0) idx_ok = 0;
    end
    rk_valid = 0;
    got = pt;
  endtask

  task automatic release_out;
    out_ready = 1;
    tick;
    out_ready = 0;
  endtask

  initial begin
    logic [127:0] p, c, got, hold;
    int lat;
    bit ok, idx_ok;
    vt[0] = '{128'h00000000_00000000_00000000_00000200, 192'h0, 128'h00000001_FFFFFFFF_00000001_00000000};
    vt[1] = '{128'h0, 192'h0, 128'h0};
    vt[2] = '{128'h12345678_00000000_00000000_00000000, 192'h0, 128'hEDCBA988_12345678_EDCBA988_12345678};
    vt[3] = '{128'h0, {192{1'b1}}, 128'hFFFFFFFE_00000000_FFFFFFFE_00000000};
    vt[4] = '{128'h00000000_00000000_00000001_00000000, 192'h0, 128'hFFFFFFE0_00000020_00000000_00000000};
    vt[5] = '{128'h00000000_20000000_00000000_00000000, 192'h0, 128'h00000001_00000000_00000000_00000000};
    key_sched(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);

    #12;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_rk_ready", 128'(rk_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_round_idx", 128'(round_idx), 128'd0);
    chk("rst_plaintext", pt, 128'd0);
    Rst_n = 1;
    tick;

    for (int i = 0; i < 6; i++) begin
      in_valid1 = 1; ct1 = vt[i].ct; rk1 = vt[i].rk;
      tick;
      in_valid1 = 0;
      chk($sformatf("r1_early_valid[%0d]", i), 128'(out_valid1), 128'd0);
      rk_valid1 = 1;
      tick;
      rk_valid1 = 0;
      chk($sformatf("r1_valid[%0d]", i), 128'(out_valid1), 128'd1);
      chk($sformatf("r1_pt[%0d]", i), pt1, vt[i].pt);
      out_ready1 = 1;
      tick;
      out_ready1 = 0;
      chk($sformatf("r1_back_idle[%0d]", i), 128'({in_ready1, out_valid1, busy1}), 128'b100);
    end

    for (int i = 0; i < 100; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      c = enc(p);
      run_block(c, 0, got, lat, idx_ok);
      chk($sformatf("rt_pt[%0d]", i), got, p);
      chk($sformatf("rt_lat[%0d]", i), 128'(lat), 128'd25);
      release_out;
    end

    for (int i = 0; i < 100; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      c = enc(p);
      run_block(c, 1, got, lat, idx_ok);
      chk($sformatf("rnd_pt[%0d]", i), got, p);
      chk($sformatf("rnd_idx[%0d]", i), 128'(idx_ok), 128'd1);
      release_out;
    end

    p = 128'h00112233_44556677_8899aabb_ccddeeff;
    run_block(enc(p), 0, got, lat, idx_ok);
    hold = got;
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; ct = ~ct;
      tick;
      if (pt !== hold || !out_valid || in_ready || !busy) ok = 0;
    end
    in_valid = 0;
    chk("done_hold_stable", 128'(ok), 128'd1);
    chk("done_hold_pt", pt, p);
    release_out;
    chk("done_exit", 128'({in_ready, out_valid, busy}), 128'b100);
    tick;
    chk("done_no_accept", 128'(busy), 128'd0);

    in_valid = 1; ct = enc(p); rk_valid = 1;
    tick;
    in_valid = 0;
    for (int i = 0; i < 14; i++) tick;
    chk("midkey_idx", 128'(round_idx), 128'd9);
    #2 Rst_n = 0;
    #1;
    chk("arst_state", 128'({in_ready, busy, out_valid, rk_ready}), 128'b1000);
    chk("arst_idx", 128'(round_idx), 128'd0);
    rk_valid = 0;
    tick;
    Rst_n = 1;
    tick;
    chk("arst_idle", 128'({in_ready, busy}), 128'b10);

`ifdef LEA_DEC_ABORT_EN
    in_valid = 1; ct = enc(p); rk_valid = 1;
    tick;
    in_valid = 0;
    lat = 0;
    while (round_idx != 5'd5 && lat < 100) begin tick; lat++; end
    abort = 1;
    tick;
    abort = 0; rk_valid = 0;
    chk("abort_idle", 128'({in_ready, busy, out_valid, rk_ready}), 128'b1000);
    chk("abort_idx", 128'(round_idx), 128'd0);
    ok = 1;
    for (int i = 0; i < 5; i++) begin tick; if (out_valid) ok = 0; end
    chk("abort_no_out", 128'(ok), 128'd1);
    p = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    run_block(enc(p), 0, got, lat, idx_ok);
    chk("abort_next_pt", got, p);
    release_out;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
